mux4_rr_arbiter: RTL and testbench

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

---
 rtl/mux4_rr_arbiter_if.sv | 22 ++
 rtl/mux4_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter
// that steers a shared 4:1 mux.
interface mux4_rr_arbiter_if;
   logic [3:0] req;
   logic [3:0] gnt;
   logic       s1;
   logic       s0;
   logic       valid;
   logic       preempt;

   // Requester side: raises req, observes grant and mux select.
   modport master (
      output req,
      input  gnt, s1, s0, valid, preempt
   );

   // Arbiter side: samples req, drives grant and mux select.
   modport slave (
      input  req,
      output gnt, s1, s0, valid, preempt
   );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin arbiter with bounded ownership. Grants are registered,
// the mux select only moves on the edge that starts a new grant, and every
// ownership change passes through a one-cycle dead SWITCH state.
module mux4_rr_arbiter #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input logic              clk,
   input logic              rst_n,
   mux4_rr_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_GRANT  = 2'd1,
      S_SWITCH = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       sel_q, sel_d;
   logic             valid_q, valid_d;
   logic             preempt_q, preempt_d;

   logic             found;
   logic [1:0]       pick;

   // Find the first requesting index, starting at ptr and wrapping mod 4.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      found = 1'b0;
      pick  = ptr_q;
      for (int k = 0; k < 4; k++) begin
         if (!found && bus.req[ptr_q + 2'(k)]) begin
            found = 1'b1;
            pick  = ptr_q + 2'(k);
         end
      end
   end

   // Next-state and next-output decode; the owner is the current select.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      gnt_d     = gnt_q;
      sel_d     = sel_q;
      valid_d   = valid_q;
      preempt_d = 1'b0;
      case (state_q)
         S_IDLE, S_SWITCH: begin
            if (found) begin
               state_d = S_GRANT;
               gnt_d   = 4'(1) << pick;
               sel_d   = pick;
               valid_d = 1'b1;
               hold_d  = CNT_W'(1);
            end else begin
               // Select keeps pointing at the last owner while idle.
               state_d = S_IDLE;
               gnt_d   = 4'b0000;
               valid_d = 1'b0;
               hold_d  = '0;
            end
         end
         S_GRANT: begin
            if (!bus.req[sel_q] || hold_q >= CNT_W'(MAX_HOLD)) begin
               // Release or timeout: drop the grant and rotate priority.
               state_d   = S_SWITCH;
               gnt_d     = 4'b0000;
               valid_d   = 1'b0;
               ptr_d     = sel_q + 2'd1;
               hold_d    = '0;
               preempt_d = bus.req[sel_q];
            end else begin
               hold_d = hold_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
            hold_d  = '0;
         end
      endcase
   end

   // State and output registers; reset clears everything including history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ptr_q     <= 2'd0;
         hold_q    <= '0;
         gnt_q     <= 4'b0000;
         sel_q     <= 2'd0;
         valid_q   <= 1'b0;
         preempt_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         gnt_q     <= gnt_d;
         sel_q     <= sel_d;
         valid_q   <= valid_d;
         preempt_q <= preempt_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.s1      = sel_q[1];
   assign bus.s0      = sel_q[0];
   assign bus.valid   = valid_q;
   assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed checks of the round-robin arbiter (default hold limit plus a
// hold limit of one), followed by a random-request run with invariant checks.
module tb_mux4_rr_arbiter;

   localparam int MAX_HOLD = 8;
   localparam int STARVE   = 3 * (MAX_HOLD + 1) + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   mux4_rr_arbiter_if bus_if ();
   mux4_rr_arbiter_if bus1_if ();

   mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   mux4_rr_arbiter #(.MAX_HOLD(1), .CNT_W(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus_if.req  = 4'b0000;
      bus1_if.req = 4'b0000;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   function automatic logic [1:0] sel();
      return {bus_if.s1, bus_if.s0};
   endfunction

   initial begin
      logic [3:0] prev_gnt;
      logic [1:0] prev_sel;
      logic       prev_valid;
      int         run;
      int         wait_cnt [4];
      int         pulses;

      bus_if.req  = 4'b0000;
      bus1_if.req = 4'b0000;

      // Asynchronous reset before any clock edge.
      #1 rst_n = 1'b0;
      #2;
      check("rst_gnt", 8'(bus_if.gnt), 8'h0);
      check("rst_sel", 8'(sel()), 8'h0);
      check("rst_valid", 8'(bus_if.valid), 8'h0);
      check("rst_preempt", 8'(bus_if.preempt), 8'h0);
      do_reset();

      // Two requesters, pointer 0: requester 1 wins one cycle later.
      bus_if.req = 4'b1010;
      check("029_pre", 8'(bus_if.gnt), 8'h0);
      tick();
      check("029_gnt", 8'(bus_if.gnt), 8'h02);
      check("029_sel", 8'(sel()), 8'h1);
      check("029_valid", 8'(bus_if.valid), 8'h1);
      tick();
      check("029_hold", 8'(bus_if.gnt), 8'h02);
      bus_if.req = 4'b0000;
      tick();
      check("029_rel_gnt", 8'(bus_if.gnt), 8'h0);
      check("029_rel_valid", 8'(bus_if.valid), 8'h0);
      check("029_rel_pre", 8'(bus_if.preempt), 8'h0);
      check("029_rel_sel", 8'(sel()), 8'h1);
      tick();
      check("029_idle_sel", 8'(sel()), 8'h1);

      // Lone requester held: 8 grant cycles, preempt dead cycle, re-grant.
      do_reset();
      bus_if.req = 4'b0001;
      pulses = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if ((c - 1) % 9 < 8) begin
            check("030_gnt", 8'(bus_if.gnt), 8'h01);
            check("030_pre", 8'(bus_if.preempt), 8'h0);
         end else begin
            check("030_dead", 8'(bus_if.gnt), 8'h0);
            check("030_pulse", 8'(bus_if.preempt), 8'h1);
         end
         if (bus_if.preempt) pulses++;
      end
      check("030_pulses", 8'(pulses), 8'd2);

      // All requesting, owners release after 2 cycles: 0,1,2,3,0.
      do_reset();
      bus_if.req = 4'b1111;
      for (int o = 0; o < 5; o++) begin
         for (int h = 0; h < 2; h++) begin
            tick();
            check("031_gnt", 8'(bus_if.gnt), 8'(4'(1) << (o % 4)));
            check("031_sel", 8'(sel()), 8'(o % 4));
         end
         bus_if.req[o % 4] = 1'b0;
         tick();
         check("031_gap", 8'(bus_if.gnt), 8'h0);
         check("031_gap_pre", 8'(bus_if.preempt), 8'h0);
         bus_if.req = 4'b1111;
      end

      // Pointer moves past 2, then owner 3 releases and wraps to 0.
      do_reset();
      bus_if.req = 4'b0100;
      tick();
      check("032_g2", 8'(bus_if.gnt), 8'h04);
      bus_if.req = 4'b0000;
      tick();
      tick();
      bus_if.req = 4'b1001;
      tick();
      check("032_ptr3", 8'(bus_if.gnt), 8'h08);
      check("032_sel3", 8'(sel()), 8'h3);
      bus_if.req = 4'b0101;
      tick();
      check("032_sw_gnt", 8'(bus_if.gnt), 8'h0);
      check("032_sw_sel", 8'(sel()), 8'h3);
      tick();
      check("032_wrap", 8'(bus_if.gnt), 8'h01);
      check("032_wrap_sel", 8'(sel()), 8'h0);

      // Non-owner requests do not disturb an active grant.
      bus_if.req = 4'b1111;
      tick();
      check("020_gnt", 8'(bus_if.gnt), 8'h01);
      check("020_sel", 8'(sel()), 8'h0);

      // Reset pulse between edges mid-grant, then fresh arbitration.
      do_reset();
      bus_if.req = 4'b0100;
      tick();
      check("033_gnt", 8'(bus_if.gnt), 8'h04);
      #2 rst_n = 1'b0;
      #1;
      check("033_async_gnt", 8'(bus_if.gnt), 8'h0);
      check("033_async_sel", 8'(sel()), 8'h0);
      check("033_async_valid", 8'(bus_if.valid), 8'h0);
      #1 rst_n = 1'b1;
      tick();
      check("033_regnt", 8'(bus_if.gnt), 8'h04);
      check("033_regnt_sel", 8'(sel()), 8'h2);

      // Hold limit of one: every grant lasts a single cycle.
      do_reset();
      bus1_if.req = 4'b0001;
      for (int c = 0; c < 4; c++) begin
         tick();
         check("h1_gnt", 8'(bus1_if.gnt), (c % 2 == 0) ? 8'h01 : 8'h00);
         check("h1_pre", 8'(bus1_if.preempt), (c % 2 == 0) ? 8'h00 : 8'h01);
      end
      bus1_if.req = 4'b0000;

      // Random slowly-changing requests with invariant checks each cycle.
      do_reset();
      prev_gnt   = 4'b0000;
      prev_sel   = 2'd0;
      prev_valid = 1'b0;
      run        = 0;
      for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
      for (int n = 0; n < 3000; n++) begin
         logic [3:0] applied;
         logic       starved;
         for (int i = 0; i < 4; i++)
            if ($urandom_range(7) == 0) bus_if.req[i] = ~bus_if.req[i];
         applied = bus_if.req;
         tick();
         check("rnd_onehot", 8'($onehot0(bus_if.gnt)), 8'h1);
         check("rnd_valid", 8'(bus_if.valid), 8'(|bus_if.gnt));
         if (bus_if.preempt) check("rnd_pre_dead", 8'(bus_if.gnt), 8'h0);
         run = bus_if.valid ? run + 1 : 0;
         check("rnd_hold", 8'(run <= MAX_HOLD), 8'h1);
         if (prev_valid && bus_if.valid)
            check("rnd_stable", 8'({bus_if.gnt, sel()} == {prev_gnt, prev_sel}), 8'h1);
         starved = 1'b0;
         for (int i = 0; i < 4; i++) begin
            wait_cnt[i] = (applied[i] && !bus_if.gnt[i]) ? wait_cnt[i] + 1 : 0;
            if (wait_cnt[i] > STARVE) starved = 1'b1;
         end
         check("rnd_starve", 8'(starved), 8'h0);
         prev_gnt   = bus_if.gnt;
         prev_sel   = sel();
         prev_valid = bus_if.valid;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
